// File: rtl/acia_tx.sv
// 8N1 serial transmitter with a small byte FIFO in front of it.
// Bytes queue on tx_stb; the bit engine drains them back-to-back with no idle gap.
module acia_tx #(
  parameter int SCW     = 16,
  parameter int sym_cnt = 40000,
  parameter int AW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_dat,
  input  logic       tx_stb,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx_ovf,
  output logic       tx_serial
);

  localparam logic [SCW-1:0] SYM_LAST = SCW'(sym_cnt - 1);
  localparam logic [AW:0]    DEPTH    = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [SCW-1:0] r_cnt;
  logic [2:0]     r_idx;
  logic [7:0]     r_shift;
  logic           r_tx;
  logic [7:0]     r_mem [2**AW];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           r_ovf;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_pop;
  logic w_load;
  logic w_shift;
  logic w_bit_end;
  logic w_tx_nxt;

  assign w_full    = (r_count == DEPTH);
  assign w_empty   = (r_count == '0);
  // Fullness is judged before the edge, so a coincident pop never rescues a write.
  assign w_wr      = tx_stb && !w_full;
  assign w_bit_end = (r_state != IDLE) && (r_cnt == SYM_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_tx_nxt    = r_tx;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_tx_nxt    = 1'b0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_tx_nxt    = r_shift[0];
          w_shift     = 1'b1;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_idx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = STOP;
          end else begin
            w_tx_nxt = r_shift[0];
            w_shift  = 1'b1;
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_load      = 1'b1;
            w_tx_nxt    = 1'b0;
            w_state_nxt = START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      if (w_load || w_bit_end || (r_state == IDLE))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + SCW'(1);
      if (w_load)
        r_idx <= '0;
      else if ((r_state == DATA) && w_bit_end)
        r_idx <= r_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (tx_stb && w_full)
        r_ovf <= 1'b1;
    end
  end

  // Storage and shift register carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr] <= tx_dat;
    if (w_load)
      r_shift <= r_mem[r_rptr];
    else if (w_shift)
      r_shift <= {1'b0, r_shift[7:1]};
  end

  assign tx_full   = w_full;
  assign tx_busy   = !w_empty || (r_state != IDLE);
  assign tx_ovf    = r_ovf;
  assign tx_serial = r_tx;

endmodule

// File: tb/tb_acia_tx.sv
// Bench for acia_tx: cycle-exact waveform checks plus a serial decoder feeding a frame scoreboard.
module tb_acia_tx;

  logic       clk;
  logic       rst;
  logic [7:0] tx_dat;
  logic       tx_stb;
  logic       tx_full, tx_busy, tx_ovf, tx_serial;
  logic [7:0] d_dat;
  logic       d_stb;
  logic       d_full, d_busy, d_ovf, d_serial;

  int checks = 0;
  int errors = 0;
  int rst_gen = 0;
  logic [9:0] rx_q[$];
  logic [7:0] exp_q[$];

  acia_tx #(.SCW(16), .sym_cnt(4), .AW(2)) u_dut (
    .clk(clk), .rst(rst), .tx_dat(tx_dat), .tx_stb(tx_stb),
    .tx_full(tx_full), .tx_busy(tx_busy), .tx_ovf(tx_ovf), .tx_serial(tx_serial)
  );

  acia_tx u_def (
    .clk(clk), .rst(rst), .tx_dat(d_dat), .tx_stb(d_stb),
    .tx_full(d_full), .tx_busy(d_busy), .tx_ovf(d_ovf), .tx_serial(d_serial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge rst) rst_gen++;

  // Serial decoder: samples each bit one cycle into it; frames cut by reset are discarded.
  initial begin : monitor
    int g;
    logic [9:0] f;
    forever begin
      @(negedge clk);
      if (tx_serial === 1'b0 && rst === 1'b0) begin
        g = rst_gen;
        @(negedge clk);
        f[8] = tx_serial;
        for (int j = 0; j < 8; j++) begin
          repeat (4) @(negedge clk);
          f[j] = tx_serial;
        end
        repeat (4) @(negedge clk);
        f[9] = tx_serial;
        if (g == rst_gen && rst === 1'b0) rx_q.push_back(f);
      end
    end
  end

  function automatic logic exp_bit(input logic [7:0] b, input int m);
    int idx;
    idx = (m - 1) / 4;
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else return 1'b1;
  endfunction

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int c;
    c = 0;
    while (tx_busy !== 1'b0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    ok = (tx_busy === 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL reset_serial: got %b expected 1", tx_serial); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", tx_full); end
    checks++; if (tx_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", tx_ovf); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One byte into an idle transmitter; waveform checked every clock.
  task automatic test_single(input logic [7:0] b);
    bit ok;
    logic [7:0] e;
    logic [9:0] f;
    @(negedge clk);
    tx_dat = b; tx_stb = 1'b1; exp_q.push_back(b);
    @(posedge clk); #1;
    tx_stb = 1'b0;
    checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL single_edge_k: got %b expected 1", tx_serial); end
    for (int m = 1; m <= 40; m++) begin
      @(posedge clk); #1;
      checks++;
      if (tx_serial !== exp_bit(b, m)) begin
        errors++; $display("FAIL single_wave byte %02h clk %0d: got %b expected %b", b, m, tx_serial, exp_bit(b, m));
      end
    end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_k40: got %b expected 1", tx_busy); end
    @(posedge clk); #1;
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_k41: got %b expected 0", tx_busy); end
    wait_rx(1, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_rx_timeout: got %0d frames expected 1", rx_q.size());
    end else begin
      f = rx_q.pop_front(); e = exp_q.pop_front();
      checks++; if (f !== {2'b10, e}) begin errors++; $display("FAIL single_frame: got %03h expected %03h", f, {2'b10, e}); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] e;
    logic [9:0] f;
    logic x;
    @(negedge clk);
    tx_dat = 8'h00; tx_stb = 1'b1; exp_q.push_back(8'h00);
    @(negedge clk);
    tx_dat = 8'hFF; exp_q.push_back(8'hFF);
    @(posedge clk); #1;
    tx_stb = 1'b0;
    for (int m = 1; m <= 80; m++) begin
      if (m > 1) begin @(posedge clk); #1; end
      x = (m <= 40) ? exp_bit(8'h00, m) : exp_bit(8'hFF, m - 40);
      checks++;
      if (tx_serial !== x) begin
        errors++; $display("FAIL b2b_wave clk %0d: got %b expected %b", m, tx_serial, x);
      end
    end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_k80: got %b expected 1", tx_busy); end
    @(posedge clk); #1;
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_k81: got %b expected 0", tx_busy); end
    wait_rx(2, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_rx_timeout: got %0d frames expected 2", rx_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        f = rx_q.pop_front(); e = exp_q.pop_front();
        checks++; if (f !== {2'b10, e}) begin errors++; $display("FAIL b2b_frame %0d: got %03h expected %03h", i, f, {2'b10, e}); end
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] e;
    logic [9:0] f;
    logic [7:0] bytes [6];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tx_dat = bytes[i]; tx_stb = 1'b1;
      if (i < 5) exp_q.push_back(bytes[i]);
      @(posedge clk); #1;
      checks++; if (tx_full !== (i >= 4)) begin errors++; $display("FAIL ovf_full write %0d: got %b expected %b", i, tx_full, (i >= 4)); end
      checks++; if (tx_ovf !== (i == 5)) begin errors++; $display("FAIL ovf_flag write %0d: got %b expected %b", i, tx_ovf, (i == 5)); end
    end
    tx_stb = 1'b0;
    wait_rx(5, 260, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL ovf_rx_timeout: got %0d frames expected 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        f = rx_q.pop_front(); e = exp_q.pop_front();
        checks++; if (f !== {2'b10, e}) begin errors++; $display("FAIL ovf_frame %0d: got %03h expected %03h", i, f, {2'b10, e}); end
      end
    end
    wait_idle(60, ok);
    repeat (50) @(posedge clk);
    checks++; if (!ok || rx_q.size() != 0) begin errors++; $display("FAIL ovf_extra_frames: got %0d extra (idle %b) expected 0", rx_q.size(), ok); end
    checks++; if (tx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", tx_ovf); end
    do_reset();
    #1;
    checks++; if (tx_ovf !== 1'b0) begin errors++; $display("FAIL ovf_cleared_by_rst: got %b expected 0", tx_ovf); end
  endtask

  // FIFO full while the first stop bit ends: the coincident write is dropped and one slot opens.
  task automatic test_full_pop();
    bit ok;
    logic [7:0] e;
    logic [9:0] f;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tx_dat = 8'hA1 + 8'(i); tx_stb = 1'b1; exp_q.push_back(8'hA1 + 8'(i));
      @(posedge clk); #1;
    end
    tx_stb = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL fp_full_before: got %b expected 1", tx_full); end
    @(negedge clk);
    tx_dat = 8'hEE; tx_stb = 1'b1;
    @(posedge clk); #1;
    tx_stb = 1'b0;
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL fp_full_after_pop: got %b expected 0", tx_full); end
    checks++; if (tx_ovf !== 1'b1) begin errors++; $display("FAIL fp_ovf: got %b expected 1", tx_ovf); end
    @(negedge clk);
    tx_dat = 8'hB6; tx_stb = 1'b1; exp_q.push_back(8'hB6);
    @(posedge clk); #1;
    tx_stb = 1'b0;
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL fp_full_refill: got %b expected 1", tx_full); end
    wait_rx(6, 260, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL fp_rx_timeout: got %0d frames expected 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        f = rx_q.pop_front(); e = exp_q.pop_front();
        checks++; if (f !== {2'b10, e}) begin errors++; $display("FAIL fp_frame %0d: got %03h expected %03h", i, f, {2'b10, e}); end
      end
    end
    wait_idle(60, ok);
    repeat (50) @(posedge clk);
    checks++; if (!ok || rx_q.size() != 0) begin errors++; $display("FAIL fp_extra_frames: got %0d extra (idle %b) expected 0", rx_q.size(), ok); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int bad;
    logic [7:0] bytes [3];
    bytes = '{8'hA5, 8'h01, 8'h02};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tx_dat = bytes[i]; tx_stb = 1'b1;
      @(posedge clk); #1;
    end
    tx_stb = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    checks++; if (tx_serial !== 1'b0) begin errors++; $display("FAIL mid_bit3_before: got %b expected 0", tx_serial); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL mid_rst_serial: got %b expected 1", tx_serial); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", tx_busy); end
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL mid_rst_full: got %b expected 0", tx_full); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_no_resume: got %0d active cycles expected 0", bad); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL mid_no_frames: got %0d frames expected 0", rx_q.size()); end
  endtask

  task automatic test_default_rate();
    int n;
    @(negedge clk);
    d_dat = 8'h41; d_stb = 1'b1;
    @(posedge clk); #1;
    d_stb = 1'b0;
    checks++; if (d_serial !== 1'b1) begin errors++; $display("FAIL def_edge_k: got %b expected 1", d_serial); end
    @(posedge clk); #1;
    checks++; if (d_busy !== 1'b1 || d_full !== 1'b0 || d_ovf !== 1'b0) begin
      errors++; $display("FAIL def_flags: got busy %b full %b ovf %b expected 1 0 0", d_busy, d_full, d_ovf);
    end
    n = 0;
    while (d_serial === 1'b0 && n < 40010) begin
      n++;
      @(posedge clk); #1;
    end
    checks++; if (n != 40000) begin errors++; $display("FAIL def_start_width: got %0d clocks expected 40000", n); end
    checks++; if (d_serial !== 1'b1) begin errors++; $display("FAIL def_bit0: got %b expected 1", d_serial); end
  endtask

  initial begin
    rst = 1'b1;
    tx_stb = 1'b0; tx_dat = 8'h00;
    d_stb = 1'b0; d_dat = 8'h00;
    test_reset();
    repeat (3) @(posedge clk);
    test_single(8'h55);
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_single(8'hC3);
    test_default_rate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
